button_conditioner: RTL and testbench

- Conditions the raw count push-button and the raw direction switch into clean single-cycle controls for the 4-bit up/down counter, which sits directly downstream.
- Synchronises both raw inputs and debounces them.
- Emits a one-cycle enable pulse per debounced press, with optional auto-repeat while the button is held.
- Drives a debounced up_down level.

---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronises and debounces a push-button and direction switch into a counter enable pulse and up_down level.
// Press reaches enable DEBOUNCE_CYCLES+2 edges after btn_raw is first sampled high; no backpressure.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic dir_raw,
    output logic enable,
    output logic up_down,
    output logic btn_level
);
    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_T  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT     = '1;
    localparam logic [DW-1:0] DIR_FULL  = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   dir_cnt_q, dir_cnt_d;
    logic            btn_meta_q, btn_meta_d, btn_s_q, btn_s_d;
    logic            dir_meta_q, dir_meta_d, dir_s_q, dir_s_d;
    logic            up_down_q, up_down_d;
    logic            enable_q, enable_d;
    logic            btn_level_q, btn_level_d;
    logic            pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            dir_meta_q  <= 1'b0;
            dir_s_q     <= 1'b0;
            state_q     <= IDLE;
            timer_q     <= '0;
            dir_cnt_q   <= '0;
            up_down_q   <= 1'b1;
            enable_q    <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            dir_meta_q  <= dir_meta_d;
            dir_s_q     <= dir_s_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_cnt_q   <= dir_cnt_d;
            up_down_q   <= up_down_d;
            enable_q    <= enable_d;
            btn_level_q <= btn_level_d;
        end
    end

    always_comb begin
        btn_meta_d = btn_raw;
        btn_s_d    = btn_meta_q;
        dir_meta_d = dir_raw;
        dir_s_d    = dir_meta_q;
    end

    // Counting to DEBOUNCE_CYCLES flips up_down on the same edge a press would be accepted.
    always_comb begin
        dir_cnt_d = dir_cnt_q;
        up_down_d = up_down_q;
        if (dir_s_q == up_down_q) begin
            dir_cnt_d = '0;
        end else if (dir_cnt_q == DIR_FULL) begin
            up_down_d = dir_s_q;
            dir_cnt_d = '0;
        end else begin
            dir_cnt_d = dir_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s_q) state_d = PRESS_DB;
            end
            PRESS_DB: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (timer_q == DEB_LAST) begin
                    state_d = HELD;
                    pulse   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_DB;
                end else if (REPEAT_EN && (timer_q == HOLD_LAST)) begin
                    state_d = REPEAT;
                    pulse   = 1'b1;
                end else if (timer_q != T_SAT) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_DB;
                end else if (timer_q == REP_LAST) begin
                    pulse   = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE_DB: begin
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (timer_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_comb begin
        enable_d    = pulse;
        btn_level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
    end

    assign enable    = enable_q;
    assign up_down   = up_down_q;
    assign btn_level = btn_level_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Drives both repeat variants of button_conditioner with directed and random button/direction traffic
// and compares every cycle against a run-length model of the debounce rules.
module tb_button_conditioner;
    localparam int D = 16;
    localparam int H = 64;
    localparam int R = 16;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic dir_raw;
    logic enable, up_down, btn_level;
    logic enable_nr, up_down_nr, btn_level_nr;

    int tests = 0;
    int failures = 0;

    // model state
    bit btn_pipe[$];
    bit dir_pipe[$];
    int hi_run, lo_run, age, mis_run;
    bit m_level, m_up, exp_en_rep, exp_en_norep;

    // scenario bookkeeping
    int n, n_nr, first, idx;
    bit rb, rd;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .dir_raw(dir_raw),
        .enable(enable), .up_down(up_down), .btn_level(btn_level)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .dir_raw(dir_raw),
        .enable(enable_nr), .up_down(up_down_nr), .btn_level(btn_level_nr)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0b expected %0b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        btn_pipe.delete(); btn_pipe.push_back(1'b0); btn_pipe.push_back(1'b0);
        dir_pipe.delete(); dir_pipe.push_back(1'b0); dir_pipe.push_back(1'b0);
        hi_run = 0; lo_run = 0; age = 0; mis_run = 0;
        m_level = 1'b0; m_up = 1'b1;
        exp_en_rep = 1'b0; exp_en_norep = 1'b0;
    endtask

    // A level change is accepted once the synchronised input has disagreed with the
    // accepted level on D+1 consecutive sampling edges; repeats come at hold ages H, H+R, ...
    task automatic model_edge(input bit b_raw, input bit d_raw);
        bit s, ds;
        s  = btn_pipe.pop_front(); btn_pipe.push_back(b_raw);
        ds = dir_pipe.pop_front(); dir_pipe.push_back(d_raw);
        exp_en_rep = 1'b0;
        exp_en_norep = 1'b0;
        if (!m_level) begin
            hi_run = s ? hi_run + 1 : 0;
            if (hi_run == D + 1) begin
                m_level = 1'b1; lo_run = 0; age = 0;
                exp_en_rep = 1'b1; exp_en_norep = 1'b1;
            end
        end else if (s) begin
            age = (lo_run > 0) ? 0 : age + 1;
            lo_run = 0;
            if (age >= H && ((age - H) % R) == 0) exp_en_rep = 1'b1;
        end else begin
            lo_run++;
            if (lo_run == D + 1) begin
                m_level = 1'b0; hi_run = 0; lo_run = 0;
            end
        end
        mis_run = (ds != m_up) ? mis_run + 1 : 0;
        if (mis_run == D + 1) begin
            m_up = ds; mis_run = 0;
        end
    endtask

    task automatic step(input bit b, input bit d);
        btn_raw = b;
        dir_raw = d;
        @(posedge clk);
        model_edge(b, d);
        #1;
        check_bit("enable", enable, exp_en_rep);
        check_bit("enable_norep", enable_nr, exp_en_norep);
        check_bit("btn_level", btn_level, m_level);
        check_bit("btn_level_norep", btn_level_nr, m_level);
        check_bit("up_down", up_down, m_up);
    endtask

    initial begin
        reset = 1'b0; btn_raw = 1'b0; dir_raw = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_bit("rst_enable", enable, 1'b0);
        check_bit("rst_btn_level", btn_level, 1'b0);
        check_bit("rst_up_down", up_down, 1'b1);
        check_bit("rst_up_down_norep", up_down_nr, 1'b1);
        #3 reset = 1'b1;
        repeat (5) step(1'b0, 1'b1);

        // clean press, 30 cycles, then release
        n = 0; first = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1);
            if (enable) begin n++; if (first < 0) first = i; end
        end
        check_int("clean_pulses", n, 1);
        check_int("clean_pulse_edge", first, D + 2);
        first = -1;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b1);
            if (!btn_level && first < 0) first = i;
        end
        check_int("clean_release_edge", first, D + 2);

        // bouncy press: toggles every 3 cycles for 40 cycles, last rise at 40
        n = 0; first = -1;
        for (int i = 0; i < 90; i++) begin
            step((i >= 40) || ((i / 3) % 2 == 0), 1'b1);
            if (enable) begin n++; if (first < 0) first = i; end
        end
        check_int("bounce_pulses", n, 1);
        check_int("bounce_pulse_edge", first, 40 + D + 2);
        repeat (25) step(1'b0, 1'b1);

        // long hold: repeat pulses at 18, 82, 98, 114
        n = 0; n_nr = 0; idx = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1, 1'b1);
            if (enable) n++;
            if (enable_nr) n_nr++;
            if (enable && i == 114) idx = i;
        end
        check_int("hold_pulses", n, 4);
        check_int("hold_pulses_norep", n_nr, 1);
        check_int("hold_last_repeat_edge", idx, 114);
        repeat (25) step(1'b0, 1'b1);

        // release bounce: low 5, high 5, then low
        n = 0; first = -1;
        for (int i = 0; i < 65; i++) begin
            step((i < 30) || (i >= 35 && i < 40), 1'b1);
            if (i >= 30 && enable) n++;
            if (i >= 30 && !btn_level && first < 0) first = i;
        end
        check_int("release_bounce_pulses", n, 0);
        check_int("release_bounce_fall", first, 40 + D + 2);

        // direction change, then a 10-cycle glitch
        first = -1;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0);
            if (!up_down && first < 0) first = i;
        end
        check_int("dir_fall_edge", first, D + 2);
        repeat (25) step(1'b0, 1'b1);
        check_bit("dir_restored", up_down, 1'b1);
        n = 0;
        for (int i = 0; i < 35; i++) begin
            step(1'b0, (i >= 10));
            if (!up_down) n++;
        end
        check_int("dir_glitch_low_cycles", n, 0);

        // random traffic
        rb = 1'b0; rd = 1'b1;
        for (int seg = 0; seg < 40; seg++) begin
            int unsigned len;
            rb = ~rb;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150) : $urandom_range(1, 20);
            for (int k = 0; k < int'(len); k++) begin
                if ($urandom_range(0, 29) == 0) rd = ~rd;
                step(rb, rd);
            end
        end

        // reset in PRESS_DB with timer at 10, up_down driven low beforehand
        repeat (25) step(1'b0, 1'b0);
        check_bit("pre_reset_up_down", up_down, 1'b0);
        repeat (13) step(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_bit("midrst_enable", enable, 1'b0);
        check_bit("midrst_btn_level", btn_level, 1'b0);
        check_bit("midrst_up_down", up_down, 1'b1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        n = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b1);
            if (enable) begin n++; if (first < 0) first = i; end
        end
        check_int("post_reset_pulses", n, 1);
        check_int("post_reset_pulse_edge", first, D + 3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
